// File: rtl/ldpc_vpu_pipe.sv
// Pipelined variable-node unit: sums intrinsic + check messages, emits saturated
// extrinsic messages, a-posteriori total and hard decision, with valid/ready flow control.
module ldpc_vpu_pipe #(
    parameter int COL_WEIGHT = 4,
    parameter int LLR_WIDTH  = 8,
    localparam int SUM_WIDTH = LLR_WIDTH + $clog2(COL_WEIGHT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_init,
    input  logic [LLR_WIDTH-1:0]            llr_intri,
    input  logic [COL_WEIGHT*LLR_WIDTH-1:0] llr_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COL_WEIGHT*LLR_WIDTH-1:0] llr_out,
    output logic [LLR_WIDTH-1:0]            llr_all,
    output logic                            hard_bit,
    output logic [15:0]                     sat_cnt,
    input  logic                            sat_clr
);

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((1 << (LLR_WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = -SAT_MAX;

    function automatic logic signed [SUM_WIDTH-1:0] sext(input logic signed [LLR_WIDTH-1:0] x);
        return SUM_WIDTH'(x);
    endfunction

    // Returns {clamped_flag, saturated_value}; the range is symmetric so -2^(W-1) never leaves.
    function automatic logic [LLR_WIDTH:0] clamp(input logic signed [SUM_WIDTH-1:0] x);
        if (x > SAT_MAX)
            return {1'b1, SAT_MAX[LLR_WIDTH-1:0]};
        else if (x < SAT_MIN)
            return {1'b1, SAT_MIN[LLR_WIDTH-1:0]};
        else
            return {1'b0, x[LLR_WIDTH-1:0]};
    endfunction

    logic                            s1_valid;
    logic signed [SUM_WIDTH-1:0]     s1_total;
    logic [COL_WEIGHT*LLR_WIDTH-1:0] s1_lanes;
    logic signed [SUM_WIDTH-1:0]     acc;
    logic [COL_WEIGHT*LLR_WIDTH-1:0] ext_bus;
    logic [LLR_WIDTH:0]              ext_c [COL_WEIGHT];
    logic [LLR_WIDTH:0]              all_c;
    logic                            sat_any;
    logic                            s1_load;
    logic                            s2_load;

    // A stage transfers on the edge where its valid and the consumer's ready are both high;
    // in_ready is combinational from the output side, so a full pipe moves 1 vector/cycle.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        acc = sext(llr_intri);
        for (int k = 0; k < COL_WEIGHT; k++) begin
            if (!in_init)
                acc = acc + sext(llr_in[k*LLR_WIDTH +: LLR_WIDTH]);
        end
    end

    for (genvar k = 0; k < COL_WEIGHT; k++) begin : g_ext
        assign ext_c[k] = clamp(s1_total - sext(s1_lanes[k*LLR_WIDTH +: LLR_WIDTH]));
        assign ext_bus[k*LLR_WIDTH +: LLR_WIDTH] = ext_c[k][LLR_WIDTH-1:0];
    end

    assign all_c = clamp(s1_total);

    always_comb begin
        sat_any = all_c[LLR_WIDTH];
        for (int k = 0; k < COL_WEIGHT; k++)
            sat_any = sat_any | ext_c[k][LLR_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_total  <= '0;
            s1_lanes  <= '0;
            out_valid <= 1'b0;
            llr_out   <= '0;
            llr_all   <= '0;
            hard_bit  <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_total <= acc;
                // Init vectors store zero lanes so stage 2 needs no mode bit.
                s1_lanes <= in_init ? '0 : llr_in;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                llr_out   <= ext_bus;
                llr_all   <= all_c[LLR_WIDTH-1:0];
                hard_bit  <= s1_total[SUM_WIDTH-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (sat_clr)
                sat_cnt <= '0;
            else if (s2_load && sat_any && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ldpc_vpu_pipe.sv
// Directed bench for ldpc_vpu_pipe: scoreboard of expected vectors checked on output transfer,
// plus reset, stall, init, sat-counter and reset-mid-stream steps.
module tb_ldpc_vpu_pipe;

    localparam int CW = 4;
    localparam int W  = 8;
    localparam int EW = CW*W + W + 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_init;
    logic [W-1:0]  llr_intri;
    logic [CW*W-1:0] llr_in;
    logic          out_valid;
    logic          out_ready;
    logic [CW*W-1:0] llr_out;
    logic [W-1:0]  llr_all;
    logic          hard_bit;
    logic [15:0]   sat_cnt;
    logic          sat_clr;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_sat  = 0;
    logic [EW-1:0] exp_q[$];

    ldpc_vpu_pipe #(.COL_WEIGHT(CW), .LLR_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_init(in_init),
        .llr_intri(llr_intri), .llr_in(llr_in), .out_valid(out_valid), .out_ready(out_ready),
        .llr_out(llr_out), .llr_all(llr_all), .hard_bit(hard_bit), .sat_cnt(sat_cnt),
        .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {sat, hard, llr_all, llr_out}, computed with plain integers.
    function automatic logic [EW-1:0] model(input logic [W-1:0] intri,
                                            input logic [CW*W-1:0] lanes, input logic init);
        int m, total, e;
        logic sat;
        logic signed [W-1:0] ls;
        logic [CW*W-1:0] o;
        m = (1 << (W-1)) - 1;
        ls = intri;
        total = ls;
        for (int k = 0; k < CW; k++) begin
            ls = lanes[k*W +: W];
            if (!init) total += ls;
        end
        sat = 1'b0;
        o = '0;
        for (int k = 0; k < CW; k++) begin
            ls = init ? '0 : lanes[k*W +: W];
            e = total - ls;
            if (e > m) begin e = m; sat = 1'b1; end
            else if (e < -m) begin e = -m; sat = 1'b1; end
            o[k*W +: W] = W'(e);
        end
        e = total;
        if (e > m) begin e = m; sat = 1'b1; end
        else if (e < -m) begin e = -m; sat = 1'b1; end
        return {sat, (total < 0), W'(e), o};
    endfunction

    function automatic logic [CW*W-1:0] lanes4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on output transfer.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(llr_intri, llr_in, in_init));
            if (out_valid && out_ready) begin
                chk_cnt++;
                assert (exp_q.size() > 0) pass_cnt++;
                else $error("FAIL out_order: observed unexpected output %0h, expected none", llr_out);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("llr_out", llr_out, e[CW*W-1:0]);
                    check("llr_all", llr_all, e[CW*W +: W]);
                    check("hard_bit", hard_bit, e[CW*W+W]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] intri, input logic [CW*W-1:0] lanes, input logic init);
        logic [EW-1:0] m;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; llr_intri = intri; llr_in = lanes; in_init = init;
        #1;
        for (int t = 0; t < 50 && !done; t++) begin
            done = in_ready;
            step();
        end
        check("send_accept", done, 1);
        in_valid = 1'b0;
        m = model(intri, lanes, init);
        if (m[EW-1]) exp_sat++;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && (exp_q.size() != 0 || out_valid); t++) step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int idx;
        logic [CW*W-1:0] held;
        logic [EW-1:0] m;
        bit acc;

        rst = 1'b1; in_valid = 1'b0; in_init = 1'b0; llr_intri = '0; llr_in = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_llr_out", llr_out, 0);
        check("rst_llr_all", llr_all, 0);
        check("rst_hard", hard_bit, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", in_ready, 1);

        // Nominal, full-scale positive and negative, init mode, zero-total and small negative.
        send(8'd5, lanes4(10, 20, 30, 40), 1'b0);
        drain();
        check("sat_cnt_nominal", sat_cnt, 16'(exp_sat));
        send(8'd127, lanes4(127, 127, 127, 127), 1'b0);
        send(8'h80, lanes4(-128, -128, -128, -128), 1'b0);
        drain();
        check("sat_cnt_extremes", sat_cnt, 16'(exp_sat));
        send(-8'sd7, 32'h55555555, 1'b1);
        send(8'd5, lanes4(1, 2, 3, 4), 1'b0);
        send(8'd0, lanes4(1, -1, 2, -2), 1'b0);
        send(-8'sd1, lanes4(-1, -1, -1, -1), 1'b0);
        drain();
        check("sat_cnt_small", sat_cnt, 16'(exp_sat));

        // Six back-to-back vectors with out_ready low on cycles 3..5.
        idx = 0;
        held = '0;
        in_valid = 1'b1; in_init = 1'b0;
        llr_intri = W'($urandom_range(0, 255)); llr_in = CW*W'($urandom());
        for (int c = 0; c < 40 && idx < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c == 3) held = llr_out;
            if (c == 4) check("stall_in_ready", in_ready, 0);
            if (c == 5) check("stall_hold", llr_out, held);
            acc = in_ready;
            step();
            if (acc) begin
                m = model(llr_intri, llr_in, 1'b0);
                if (m[EW-1]) exp_sat++;
                idx++;
                llr_intri = W'($urandom_range(0, 255)); llr_in = CW*W'($urandom());
            end
        end
        in_valid = 1'b0;
        check("stream_accepted", idx, 6);
        drain();
        check("sat_cnt_stream", sat_cnt, 16'(exp_sat));

        // Reset with two vectors in flight: nothing may emerge afterwards.
        out_ready = 1'b0;
        send(8'd3, lanes4(127, 127, 1, 1), 1'b0);
        send(8'd4, lanes4(2, 2, 2, 2), 1'b0);
        check("inflight_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_sat = 0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        out_ready = 1'b1;
        step(); step(); step();
        check("midrst_no_emit", out_valid, 0);

        // sat_clr on the same edge a saturated result loads wins over the increment.
        send(8'd127, lanes4(100, 100, 0, 0), 1'b0);
        drain();
        check("sat_cnt_one", sat_cnt, 16'(exp_sat));
        in_valid = 1'b1; llr_intri = 8'd127; llr_in = lanes4(127, 127, 127, 127); in_init = 1'b0;
        step();
        in_valid = 1'b0;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        exp_sat = 0;
        drain();
        check("sat_clr_wins", sat_cnt, 16'(exp_sat));
        send(8'h80, lanes4(-128, 0, 0, 0), 1'b0);
        drain();
        check("sat_cnt_after_clr", sat_cnt, 16'(exp_sat));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
